// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel synchronise, glitch-filter and edge-detect with mode-qualified events
// Ports:
//   clk, reset_n       clock and asynchronous active-low reset
//   signal_in          raw asynchronous inputs, one per channel
//   mode               per channel 2 bits: 00 off, 01 rise, 10 fall, 11 both
//   clear              per-channel clear of sticky flag and event counter
//   level              filtered level per channel
//   rising_pulse       1-cycle pulse on filtered 0->1
//   falling_pulse      1-cycle pulse on filtered 1->0
//   event_pulse        1-cycle pulse on a mode-qualified edge
//   event_sticky       latched event flag, held until clear
//   event_count        saturating event counters, ch i at [i*CNT_WIDTH +: CNT_WIDTH]
//   irq                registered OR of all sticky flags
module multi_edge_detector #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CHANNELS-1:0]           signal_in,
    input  logic [2*CHANNELS-1:0]         mode,
    input  logic [CHANNELS-1:0]           clear,
    output logic [CHANNELS-1:0]           level,
    output logic [CHANNELS-1:0]           rising_pulse,
    output logic [CHANNELS-1:0]           falling_pulse,
    output logic [CHANNELS-1:0]           event_pulse,
    output logic [CHANNELS-1:0]           event_sticky,
    output logic [CHANNELS*CNT_WIDTH-1:0] event_count,
    output logic                          irq
);
    localparam int FW = $clog2(FILTER_LEN) + 1;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic [FW-1:0]          flt;
        logic [CNT_WIDTH-1:0]   cnt;
        logic                   lvl, rise_q, fall_q, ev_q, sticky;
        logic                   s, fire, ev;
        assign s    = sync[SYNC_STAGES-1];
        // accept the new level once it has differed for FILTER_LEN consecutive edges
        assign fire = (s != lvl) && (flt == FW'(FILTER_LEN - 1));
        assign ev   = fire && ((s && mode[2*i]) || (!s && mode[2*i+1]));
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync   <= '0;
                flt    <= '0;
                lvl    <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                ev_q   <= 1'b0;
                sticky <= 1'b0;
                cnt    <= '0;
            end else begin
                sync   <= {sync[SYNC_STAGES-2:0], signal_in[i]};
                flt    <= (s == lvl || fire) ? '0 : flt + FW'(1);
                lvl    <= fire ? s : lvl;
                rise_q <= fire && s;
                fall_q <= fire && !s;
                ev_q   <= ev;
                // a coincident event wins over clear so it is never lost
                sticky <= ev || (sticky && !clear[i]);
                if (clear[i])
                    cnt <= CNT_WIDTH'(ev);
                else if (ev && cnt != '1)
                    cnt <= cnt + CNT_WIDTH'(1);
            end
        end
        assign level[i]                             = lvl;
        assign rising_pulse[i]                      = rise_q;
        assign falling_pulse[i]                     = fall_q;
        assign event_pulse[i]                       = ev_q;
        assign event_sticky[i]                      = sticky;
        assign event_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= |event_sticky;
    end
endmodule
